ctrl_pipe: RTL and testbench
============================

// Module: ctrl_pipe
// PURPOSE
//  Successor to the fixed 5-stage controller: decodes the RV32I instruction in D, registers a packed
//  control word + rd index through E, MEM_LAT memory stages and W, with per-stage valid bits.
//  Detects load-use hazards internally and drives the D-stall; applies redirect/error flushes.
//  Sits between the instruction register (D) and the datapath/hazard logic.
// PARAMETERS
//  XLEN     32  instruction width (fixed 32; checked by elaboration assertion)
//  MEM_LAT  1   memory stages between E and W (1 or 2); stage names M1[,M2]
//  ALUOP_W  5   width of alucontrol
// PORTS
//  clk            in   1        rising-edge clock
//  rst_n          in   1        asynchronous active-low reset
//  instr_d        in   32       instruction in D
//  instr_valid_d  in   1        instr_d holds a real instruction
//  redirect       in   1        taken branch not predicted (pcsrc & ~correct): flush D->E and E->M1
//  error          in   1        exception: flush every stage except W
//  immsel_d       out  3        immediate format for D (combinational)
//  illegal_d      out  1        valid D instruction not decodable (combinational)
//  stall_d        out  1        load-use stall: hold PC/D, inject bubble into E (combinational)
//  alusrc_e, memread_e, regwrite_e  out 1;  alucontrol_e out ALUOP_W;  rd_e out 5;  valid_e out 1
//  memread_m, memwrite_m, regwrite_m out 1;  load_store_m out 3;  branch_m out 8;  rd_m out 5;  valid_m out 1
//  regsrc_w, regwrite_w out 1;  rd_w out 5;  valid_w out 1
// BEHAVIOUR
//  - Reset: every stage register, valid and control output = 0; async assert, sync-safe deassert.
//  - Encodings (ctrl_pkg): branch one-hot [0]beq [1]bge [2]bgeu [3]blt [4]bltu [5]bne [6]jal [7]jalr;
//    load_store 0 lb 1 lbu 2 lh 3 lhu 4 lw 5 sb 6 sh 7 sw; immsel 0 R 1 I-shamt 2 I 3 S 4 B 5 J 6 U.
//  - Decode: full RV32I incl. sltu/sltiu; unlisted opcode/funct3/funct7 -> illegal_d=1, word all-zero.
//    instr_valid_d=0 or illegal -> bubble enters E.
//  - Latency: control word visible at E 1 cycle after D, M1 2, W 2+MEM_LAT; m outputs tap M1.
//  - Stall: stall_d = valid_e & memread_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d), rs use per format;
//    MEM_LAT=2 also compares load in M1. Under stall E gets bubble, downstream advances.
//  - Flush priority: error > redirect > stall. redirect: E and M1 load bubbles; error: E..M_last bubbles;
//    W always advances. stall_d forced 0 when redirect|error.
//  - Bubble = valid 0 and all controls 0; no output ever asserts with valid 0.
//  - rd forced 0 when regwrite=0; writes to x0 leave regwrite_w=1 (regfile ignores).
//  - Reset mid-flight: all in-flight words dropped, first post-reset instruction decodes normally.
// CONFIGURATION
//  RV32M_EN defined: op 0x33/funct7 0000001 decodes mul,mulh,mulhsu,mulhu,div,divu,rem,remu to
//  alucontrol 10100..11011, regwrite=1, immsel R. Undefined: those encodings raise illegal_d.
// STRUCTURE
//  ctrl_pkg: ALU op codes, branch bit indices, load_store/immsel codes, packed ctrl_word_t struct.
//  ctrl_decode: combinational sub-module (instr -> ctrl_word_t, illegal, rs1/rs2 use flags).
//  Top: hazard compare + generate loop of MEM_LAT+2 stage registers with per-stage clear.
// TESTING
//  add x3,x1,x2 -> alucontrol_e=00001 next cycle, regwrite_w=1 rd_w=3 at cycle 2+MEM_LAT.
//  lw x5,0(x1) then add x6,x5,x2 -> stall_d=1 for MEM_LAT cycles, bubble valid_e=0, then add proceeds.
//  beq in E with redirect=1 -> valid_e and valid_m go 0 next cycle; W untouched.
//  stall and error same cycle -> stall_d=0, all stages but W bubble.
//  rst_n low during sw in M1 -> memwrite_m=0 immediately; 0x0000007F -> illegal_d=1, no regwrite.
//  RV32M_EN: mul x7,x1,x2 -> alucontrol_e=10100; without macro -> illegal_d=1.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pkg: shared encodings for the RV32I control pipeline.
//   ALU op codes, branch one-hot bit indices, load_store and immsel codes,
//   the packed control word carried E->W, and the load-use hit helper.
// Optional feature macro used by the decoder: RV32M_EN.
package ctrl_pkg;

  localparam int ALU_W = 5;

  localparam logic [ALU_W-1:0] ALU_NOP   = 5'd0;
  localparam logic [ALU_W-1:0] ALU_ADD   = 5'd1;
  localparam logic [ALU_W-1:0] ALU_SUB   = 5'd2;
  localparam logic [ALU_W-1:0] ALU_SLL   = 5'd3;
  localparam logic [ALU_W-1:0] ALU_SLT   = 5'd4;
  localparam logic [ALU_W-1:0] ALU_SLTU  = 5'd5;
  localparam logic [ALU_W-1:0] ALU_XOR   = 5'd6;
  localparam logic [ALU_W-1:0] ALU_SRL   = 5'd7;
  localparam logic [ALU_W-1:0] ALU_SRA   = 5'd8;
  localparam logic [ALU_W-1:0] ALU_OR    = 5'd9;
  localparam logic [ALU_W-1:0] ALU_AND   = 5'd10;
  localparam logic [ALU_W-1:0] ALU_LUI   = 5'd11;
  localparam logic [ALU_W-1:0] ALU_AUIPC = 5'd12;
  // mul,mulh,mulhsu,mulhu,div,divu,rem,remu = ALU_MUL + funct3
  localparam logic [ALU_W-1:0] ALU_MUL   = 5'b10100;

  localparam int BR_BEQ  = 0;
  localparam int BR_BGE  = 1;
  localparam int BR_BGEU = 2;
  localparam int BR_BLT  = 3;
  localparam int BR_BLTU = 4;
  localparam int BR_BNE  = 5;
  localparam int BR_JAL  = 6;
  localparam int BR_JALR = 7;

  localparam logic [2:0] LS_LB  = 3'd0;
  localparam logic [2:0] LS_LBU = 3'd1;
  localparam logic [2:0] LS_LH  = 3'd2;
  localparam logic [2:0] LS_LHU = 3'd3;
  localparam logic [2:0] LS_LW  = 3'd4;
  localparam logic [2:0] LS_SB  = 3'd5;
  localparam logic [2:0] LS_SH  = 3'd6;
  localparam logic [2:0] LS_SW  = 3'd7;

  localparam logic [2:0] IMM_R  = 3'd0;
  localparam logic [2:0] IMM_SH = 3'd1;
  localparam logic [2:0] IMM_I  = 3'd2;
  localparam logic [2:0] IMM_S  = 3'd3;
  localparam logic [2:0] IMM_B  = 3'd4;
  localparam logic [2:0] IMM_J  = 3'd5;
  localparam logic [2:0] IMM_U  = 3'd6;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LD    = 7'h03;
  localparam logic [6:0] OP_ST    = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_FENCE = 7'h0F;

  typedef struct packed {
    logic             alusrc;
    logic             memread;
    logic             memwrite;
    logic             regwrite;
    logic             regsrc;     // 1: W result comes from memory
    logic [ALU_W-1:0] alucontrol;
    logic [2:0]       load_store;
    logic [7:0]       branch;
    logic [4:0]       rd;         // 0 whenever regwrite=0
  } ctrl_word_t;

  typedef struct packed {
    logic       valid;
    ctrl_word_t w;
  } stage_t;

  // A load sitting in stage s whose destination is read by the D instruction.
  function automatic logic load_hit(stage_t s, logic [4:0] rs1, logic [4:0] rs2,
                                    logic use1, logic use2);
    return s.valid && s.w.memread && (s.w.rd != 5'd0) &&
           ((use1 && (s.w.rd == rs1)) || (use2 && (s.w.rd == rs2)));
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: D-stage inputs, flush controls and per-stage control outputs
// of the control pipeline.
//   master: instruction source / hazard+datapath side (drives instr, redirect, error)
//   slave : ctrl_pipe
interface ctrl_pipe_if #(parameter int ALUOP_W = 5);
  logic [31:0]        instr_d;
  logic               instr_valid_d;
  logic               redirect;
  logic               error;

  logic [2:0]         immsel_d;
  logic               illegal_d;
  logic               stall_d;

  logic               alusrc_e, memread_e, regwrite_e, valid_e;
  logic [ALUOP_W-1:0] alucontrol_e;
  logic [4:0]         rd_e;

  logic               memread_m, memwrite_m, regwrite_m, valid_m;
  logic [2:0]         load_store_m;
  logic [7:0]         branch_m;
  logic [4:0]         rd_m;

  logic               regsrc_w, regwrite_w, valid_w;
  logic [4:0]         rd_w;

  modport master (
    output instr_d, instr_valid_d, redirect, error,
    input  immsel_d, illegal_d, stall_d,
           alusrc_e, memread_e, regwrite_e, valid_e, alucontrol_e, rd_e,
           memread_m, memwrite_m, regwrite_m, valid_m, load_store_m, branch_m, rd_m,
           regsrc_w, regwrite_w, valid_w, rd_w
  );

  modport slave (
    input  instr_d, instr_valid_d, redirect, error,
    output immsel_d, illegal_d, stall_d,
           alusrc_e, memread_e, regwrite_e, valid_e, alucontrol_e, rd_e,
           memread_m, memwrite_m, regwrite_m, valid_m, load_store_m, branch_m, rd_m,
           regsrc_w, regwrite_w, valid_w, rd_w
  );
endinterface

// File: rtl/ctrl_pipe_decode.sv
// ctrl_decode: combinational RV32I decoder.
//   instr   in  32  instruction word
//   word    out     control word (all-zero when illegal)
//   immsel  out 3   immediate format (0 when illegal)
//   illegal out 1   encoding not recognised
//   use_rs1/use_rs2 out 1  format actually reads rs1/rs2 (gates hazard compare)
// RV32M_EN defined: op 0x33 / funct7 0000001 decodes the M extension.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_word_t  word,
  output logic [2:0]  immsel,
  output logic        illegal,
  output logic        use_rs1,
  output logic        use_rs2
);

  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [4:0] rd;
  logic [9:0] rs_unused;

  assign op = instr[6:0];
  assign rd = instr[11:7];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  // register indices are compared in the top; keep them visibly consumed here
  assign rs_unused = instr[24:15];

  always_comb begin
    word    = '0;
    immsel  = IMM_R;
    illegal = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (op)
      OP_R: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; word.regwrite = 1'b1;
        case (f7)
          7'b0000000:
            case (f3)
              3'd0: word.alucontrol = ALU_ADD;
              3'd1: word.alucontrol = ALU_SLL;
              3'd2: word.alucontrol = ALU_SLT;
              3'd3: word.alucontrol = ALU_SLTU;
              3'd4: word.alucontrol = ALU_XOR;
              3'd5: word.alucontrol = ALU_SRL;
              3'd6: word.alucontrol = ALU_OR;
              default: word.alucontrol = ALU_AND;
            endcase
          7'b0100000:
            case (f3)
              3'd0: word.alucontrol = ALU_SUB;
              3'd5: word.alucontrol = ALU_SRA;
              default: illegal = 1'b1;
            endcase
`ifdef RV32M_EN
          7'b0000001: word.alucontrol = ALU_MUL + {2'b00, f3};
`endif
          default: illegal = 1'b1;
        endcase
      end
      OP_I: begin
        use_rs1 = 1'b1; word.regwrite = 1'b1; word.alusrc = 1'b1; immsel = IMM_I;
        case (f3)
          3'd0: word.alucontrol = ALU_ADD;
          3'd2: word.alucontrol = ALU_SLT;
          3'd3: word.alucontrol = ALU_SLTU;
          3'd4: word.alucontrol = ALU_XOR;
          3'd6: word.alucontrol = ALU_OR;
          3'd7: word.alucontrol = ALU_AND;
          3'd1: begin
            immsel = IMM_SH;
            if (f7 == 7'b0000000) word.alucontrol = ALU_SLL;
            else                  illegal = 1'b1;
          end
          default: begin
            immsel = IMM_SH;
            if      (f7 == 7'b0000000) word.alucontrol = ALU_SRL;
            else if (f7 == 7'b0100000) word.alucontrol = ALU_SRA;
            else                       illegal = 1'b1;
          end
        endcase
      end
      OP_LD: begin
        use_rs1 = 1'b1; immsel = IMM_I; word.alucontrol = ALU_ADD;
        word.memread = 1'b1; word.regwrite = 1'b1; word.regsrc = 1'b1; word.alusrc = 1'b1;
        case (f3)
          3'd0: word.load_store = LS_LB;
          3'd1: word.load_store = LS_LH;
          3'd2: word.load_store = LS_LW;
          3'd4: word.load_store = LS_LBU;
          3'd5: word.load_store = LS_LHU;
          default: illegal = 1'b1;
        endcase
      end
      OP_ST: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; immsel = IMM_S; word.alucontrol = ALU_ADD;
        word.memwrite = 1'b1; word.alusrc = 1'b1;
        case (f3)
          3'd0: word.load_store = LS_SB;
          3'd1: word.load_store = LS_SH;
          3'd2: word.load_store = LS_SW;
          default: illegal = 1'b1;
        endcase
      end
      OP_BR: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; immsel = IMM_B; word.alucontrol = ALU_SUB;
        case (f3)
          3'd0: word.branch[BR_BEQ]  = 1'b1;
          3'd1: word.branch[BR_BNE]  = 1'b1;
          3'd4: word.branch[BR_BLT]  = 1'b1;
          3'd5: word.branch[BR_BGE]  = 1'b1;
          3'd6: word.branch[BR_BLTU] = 1'b1;
          3'd7: word.branch[BR_BGEU] = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        immsel = IMM_J; word.alucontrol = ALU_ADD; word.regwrite = 1'b1;
        word.branch[BR_JAL] = 1'b1;
      end
      OP_JALR: begin
        use_rs1 = 1'b1; immsel = IMM_I; word.alucontrol = ALU_ADD;
        word.regwrite = 1'b1; word.alusrc = 1'b1; word.branch[BR_JALR] = 1'b1;
        if (f3 != 3'd0) illegal = 1'b1;
      end
      OP_LUI: begin
        immsel = IMM_U; word.alucontrol = ALU_LUI; word.regwrite = 1'b1; word.alusrc = 1'b1;
      end
      OP_AUIPC: begin
        immsel = IMM_U; word.alucontrol = ALU_AUIPC; word.regwrite = 1'b1; word.alusrc = 1'b1;
      end
      // fence carries no datapath control: a valid, empty word
      OP_FENCE: if (f3 != 3'd0) illegal = 1'b1;
      default: illegal = 1'b1;
    endcase

    word.rd = word.regwrite ? rd : 5'd0;

    if (illegal) begin
      word    = '0;
      immsel  = IMM_R;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: RV32I control pipeline D -> E -> M1[..M2] -> W.
//   clk, rst_n : rising-edge clock, async active-low reset
//   bus        : ctrl_pipe_if.slave (instr_d/instr_valid_d/redirect/error in;
//                immsel_d/illegal_d/stall_d combinational; *_e, *_m (M1 tap), *_w registered)
// Params: XLEN (must be 32), MEM_LAT (1 or 2 memory stages), ALUOP_W (alucontrol width).
// Optional feature macro: RV32M_EN (M-extension decode, see ctrl_decode).
// Flush priority error > redirect > stall. W always advances.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MEM_LAT = 1,
  parameter int ALUOP_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  ctrl_pipe_if.slave  bus
);

  localparam int NST   = MEM_LAT + 2;  // E, M1..M_last, W
  localparam int W_IDX = MEM_LAT + 1;

  if (XLEN != 32 || MEM_LAT < 1 || MEM_LAT > 2 || ALUOP_W < ALU_W) begin : g_param_chk
    $error("ctrl_pipe: XLEN must be 32, MEM_LAT 1..2, ALUOP_W >= 5");
  end

  ctrl_word_t dec_word;
  logic [2:0] dec_immsel;
  logic       dec_illegal, use_rs1, use_rs2;
  logic       dec_ok, hit_e, hit_m1, stall;

  ctrl_decode u_dec (
    .instr   (bus.instr_d),
    .word    (dec_word),
    .immsel  (dec_immsel),
    .illegal (dec_illegal),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
  );

  assign dec_ok        = bus.instr_valid_d & ~dec_illegal;
  assign bus.immsel_d  = dec_immsel;
  assign bus.illegal_d = bus.instr_valid_d & dec_illegal;

  // load-use: the consumer must sit in D while its load is still short of W-forwarding
  assign hit_e  = load_hit(g_stage[0].q, bus.instr_d[19:15], bus.instr_d[24:20],
                           use_rs1, use_rs2);
  assign hit_m1 = (MEM_LAT == 2) ? load_hit(g_stage[1].q, bus.instr_d[19:15],
                                            bus.instr_d[24:20], use_rs1, use_rs2)
                                 : 1'b0;
  // a flush discards D anyway, so holding it would only lose a cycle
  assign stall       = dec_ok & (hit_e | hit_m1) & ~bus.redirect & ~bus.error;
  assign bus.stall_d = stall;

  for (genvar i = 0; i < NST; i++) begin : g_stage
    stage_t q, d;
    logic   clr;

    if (i == 0) begin : g_e
      assign d.valid = dec_ok;
      assign d.w     = dec_ok ? dec_word : '0;
      assign clr     = stall | bus.redirect | bus.error;
    end else begin : g_fwd
      assign d   = g_stage[i-1].q;
      assign clr = (i == W_IDX) ? 1'b0
                 : (i == 1)     ? (bus.redirect | bus.error)
                 :                bus.error;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   q <= '0;
      else if (clr) q <= '0;
      else          q <= d;
    end
  end

  stage_t e_q, m_q, w_q;
  assign e_q = g_stage[0].q;
  assign m_q = g_stage[1].q;
  assign w_q = g_stage[W_IDX].q;

  assign bus.alusrc_e     = e_q.w.alusrc;
  assign bus.memread_e    = e_q.w.memread;
  assign bus.regwrite_e   = e_q.w.regwrite;
  assign bus.alucontrol_e = ALUOP_W'(e_q.w.alucontrol);
  assign bus.rd_e         = e_q.w.rd;
  assign bus.valid_e      = e_q.valid;

  assign bus.memread_m    = m_q.w.memread;
  assign bus.memwrite_m   = m_q.w.memwrite;
  assign bus.regwrite_m   = m_q.w.regwrite;
  assign bus.load_store_m = m_q.w.load_store;
  assign bus.branch_m     = m_q.w.branch;
  assign bus.rd_m         = m_q.w.rd;
  assign bus.valid_m      = m_q.valid;

  assign bus.regsrc_w     = w_q.w.regsrc;
  assign bus.regwrite_w   = w_q.w.regwrite;
  assign bus.rd_w         = w_q.w.rd;
  assign bus.valid_w      = w_q.valid;

  // W needs only writeback fields; the rest of the word ends here
  logic unused_w;
  assign unused_w = ^{w_q.w.alusrc, w_q.w.memread, w_q.w.memwrite, w_q.w.alucontrol,
                      w_q.w.load_store, w_q.w.branch, e_q.w.memwrite, e_q.w.regsrc,
                      e_q.w.load_store, e_q.w.branch, m_q.w.alusrc, m_q.w.regsrc,
                      m_q.w.alucontrol};

endmodule

// File: tb/tb_ctrl_pipe.sv
`timescale 1ns/1ps
module tb_ctrl_pipe;
  localparam int MEM_LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  ctrl_pipe_if #(.ALUOP_W(5)) bus ();

  ctrl_pipe #(.XLEN(32), .MEM_LAT(MEM_LAT), .ALUOP_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic v);
    bus.instr_d = ins; bus.instr_valid_d = v;
  endtask

  task automatic flush_pipe();
    drive(32'h0, 1'b0);
    repeat (MEM_LAT + 3) tick();
  endtask

  function automatic logic [31:0] r_ins(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] i_ins(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_ins(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_ins(logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {7'b0, rs2, rs1, f3, 5'b01000, 7'h63};
  endfunction

  typedef struct {
    string       nm;
    logic [31:0] instr;
    logic        vld;
    logic        ill;
    logic [2:0]  imm;
    logic        ve;
    logic [4:0]  alu;
    logic        rw, mr, as;
    logic [4:0]  rd;
  } vec_t;

  vec_t tv[$];

  initial begin
    //        name     instr                              vld ill imm ve alu  rw mr as rd
    tv.push_back('{"add",   r_ins(7'h00,2,1,0,3),         1, 0, 0, 1, 1,   1, 0, 0, 3});
    tv.push_back('{"sub",   r_ins(7'h20,2,1,0,4),         1, 0, 0, 1, 2,   1, 0, 0, 4});
    tv.push_back('{"sltu",  r_ins(7'h00,2,1,3,5),         1, 0, 0, 1, 5,   1, 0, 0, 5});
    tv.push_back('{"sra",   r_ins(7'h20,2,1,5,6),         1, 0, 0, 1, 8,   1, 0, 0, 6});
    tv.push_back('{"sltiu", i_ins(12'd5,1,3,7,7'h13),     1, 0, 2, 1, 5,   1, 0, 1, 7});
    tv.push_back('{"srai",  i_ins({7'h20,5'd3},1,5,8,7'h13), 1, 0, 1, 1, 8, 1, 0, 1, 8});
    tv.push_back('{"lw",    i_ins(12'd0,1,2,9,7'h03),     1, 0, 2, 1, 1,   1, 1, 1, 9});
    tv.push_back('{"sw",    s_ins(12'd4,2,1,2),           1, 0, 3, 1, 1,   0, 0, 1, 0});
    tv.push_back('{"beq",   b_ins(2,1,0),                 1, 0, 4, 1, 2,   0, 0, 0, 0});
    tv.push_back('{"jal",   {20'h00400,5'd1,7'h6F},       1, 0, 5, 1, 1,   1, 0, 0, 1});
    tv.push_back('{"lui",   {20'h12345,5'd10,7'h37},      1, 0, 6, 1, 11,  1, 0, 1, 10});
    tv.push_back('{"op7f",  32'h0000007F,                 1, 1, 0, 0, 0,   0, 0, 0, 0});
    tv.push_back('{"badf7", r_ins(7'h02,2,1,0,3),         1, 1, 0, 0, 0,   0, 0, 0, 0});
    tv.push_back('{"badld", i_ins(12'd0,1,3,9,7'h03),     1, 1, 0, 0, 0,   0, 0, 0, 0});
    tv.push_back('{"novld", r_ins(7'h00,2,1,0,3),         0, 0, 0, 0, 0,   0, 0, 0, 0});
`ifdef RV32M_EN
    tv.push_back('{"mul",   r_ins(7'h01,2,1,0,7),         1, 0, 0, 1, 20,  1, 0, 0, 7});
`else
    tv.push_back('{"mul",   r_ins(7'h01,2,1,0,7),         1, 1, 0, 0, 0,   0, 0, 0, 0});
`endif

    drive(r_ins(7'h00,2,1,0,3), 1'b1);
    bus.redirect = 1'b0; bus.error = 1'b0;

    // reset: nothing enters even with a valid instruction presented
    repeat (2) @(posedge clk);
    #1;
    chk("rst e", {bus.valid_e, bus.regwrite_e, bus.alucontrol_e, bus.rd_e}, 0);
    chk("rst m", {bus.valid_m, bus.memread_m, bus.memwrite_m, bus.regwrite_m, bus.branch_m}, 0);
    chk("rst w", {bus.valid_w, bus.regwrite_w, bus.regsrc_w, bus.rd_w}, 0);
    chk("rst stall", bus.stall_d, 0);
    rst_n = 1'b1;
    flush_pipe();

    // decode table
    foreach (tv[k]) begin
      drive(tv[k].instr, tv[k].vld);
      #1;
      chk({tv[k].nm, " illegal_d"}, bus.illegal_d, tv[k].ill);
      chk({tv[k].nm, " immsel_d"}, bus.immsel_d, tv[k].imm);
      tick();
      chk({tv[k].nm, " e-stage"},
          {bus.valid_e, bus.alucontrol_e, bus.regwrite_e, bus.memread_e, bus.alusrc_e, bus.rd_e},
          {tv[k].ve, tv[k].alu, tv[k].rw, tv[k].mr, tv[k].as, tv[k].rd});
    end

    // latency: add x3,x1,x2 through E, M1, W
    flush_pipe();
    drive(r_ins(7'h00,2,1,0,3), 1'b1);
    tick();
    drive(32'h0, 1'b0);
    chk("lat e", {bus.valid_e, bus.alucontrol_e, bus.rd_e}, {1'b1, 5'd1, 5'd3});
    tick();
    chk("lat m", {bus.valid_m, bus.regwrite_m, bus.rd_m}, {1'b1, 1'b1, 5'd3});
    repeat (MEM_LAT - 1) tick();
    tick();
    chk("lat w", {bus.valid_w, bus.regwrite_w, bus.regsrc_w, bus.rd_w}, {1'b1, 1'b1, 1'b0, 5'd3});

    // bne one-hot in M
    flush_pipe();
    drive(b_ins(2,1,1), 1'b1);
    tick(); drive(32'h0, 1'b0); tick();
    chk("bne m", {bus.valid_m, bus.branch_m, bus.regwrite_m, bus.rd_m}, {1'b1, 8'h20, 1'b0, 5'd0});

    // load-use: lw x5,0(x1) ; add x6,x5,x2
    flush_pipe();
    drive(i_ins(12'd0,1,2,5,7'h03), 1'b1);
    #1 chk("lu pre stall", bus.stall_d, 0);
    tick();
    drive(r_ins(7'h00,2,5,0,6), 1'b1);
    #1 chk("lu stall", bus.stall_d, 1);
    tick();
    chk("lu bubble e", {bus.valid_e, bus.regwrite_e, bus.rd_e}, 0);
    chk("lu load m", {bus.valid_m, bus.memread_m, bus.rd_m}, {1'b1, 1'b1, 5'd5});
    for (int k = 1; k < MEM_LAT; k++) begin
      chk("lu stall2", bus.stall_d, 1);
      tick();
      chk("lu bubble2", bus.valid_e, 0);
    end
    chk("lu release", bus.stall_d, 0);
    tick();
    drive(32'h0, 1'b0);
    chk("lu add e", {bus.valid_e, bus.alucontrol_e, bus.rd_e}, {1'b1, 5'd1, 5'd6});
    chk("lu load w", {bus.valid_w, bus.regsrc_w, bus.regwrite_w, bus.rd_w}, {1'b1, 1'b1, 1'b1, 5'd5});

    // hazard boundaries against lw x5 in E
    flush_pipe();
    drive(i_ins(12'd0,1,2,5,7'h03), 1'b1);
    tick();
    drive({20'h00028,5'd11,7'h37}, 1'b1);       // lui: rs1 field = 5, but not read
    #1 chk("haz lui", bus.stall_d, 0);
    drive(s_ins(12'd0,5,1,2), 1'b1);            // sw x5,0(x1): rs2 match
    #1 chk("haz sw rs2", bus.stall_d, 1);
    drive(s_ins(12'd0,5,1,2), 1'b0);
    #1 chk("haz invalid d", bus.stall_d, 0);
    drive(s_ins(12'd0,5,1,2), 1'b1);
    bus.redirect = 1'b1;
    #1 chk("haz redirect", bus.stall_d, 0);
    bus.redirect = 1'b0;
    drive(32'h0, 1'b0);
    flush_pipe();
    drive(i_ins(12'd0,1,2,0,7'h03), 1'b1);      // lw x0
    tick();
    drive(r_ins(7'h00,2,0,0,6), 1'b1);
    #1 chk("haz x0", bus.stall_d, 0);

    // redirect with beq in E, add x3 in M1
    flush_pipe();
    drive(r_ins(7'h00,2,1,0,3), 1'b1);
    tick();
    drive(b_ins(2,1,0), 1'b1);
    tick();
    drive(r_ins(7'h00,2,1,0,4), 1'b1);
    bus.redirect = 1'b1;
    tick();
    bus.redirect = 1'b0;
    drive(32'h0, 1'b0);
    chk("redir e/m", {bus.valid_e, bus.valid_m, bus.branch_m, bus.regwrite_e}, 0);
    chk("redir w", {bus.valid_w, bus.regwrite_w, bus.rd_w}, {1'b1, 1'b1, 5'd3});

    // stall and error together: lw x5 in E, add x3 in M1, add x6,x5 in D
    flush_pipe();
    drive(r_ins(7'h00,2,1,0,3), 1'b1);
    tick();
    drive(i_ins(12'd0,1,2,5,7'h03), 1'b1);
    tick();
    drive(r_ins(7'h00,2,5,0,6), 1'b1);
    bus.error = 1'b1;
    #1 chk("err stall", bus.stall_d, 0);
    tick();
    bus.error = 1'b0;
    drive(32'h0, 1'b0);
    chk("err e/m", {bus.valid_e, bus.valid_m, bus.memread_m, bus.rd_e, bus.rd_m}, 0);
    chk("err w", {bus.valid_w, bus.regwrite_w, bus.rd_w}, {1'b1, 1'b1, 5'd3});

    // reset while sw sits in M1
    flush_pipe();
    drive(s_ins(12'd4,2,1,2), 1'b1);
    tick();
    drive(32'h0, 1'b0);
    tick();
    chk("sw m", {bus.valid_m, bus.memwrite_m, bus.load_store_m, bus.regwrite_m, bus.rd_m},
        {1'b1, 1'b1, 3'd7, 1'b0, 5'd0});
    #2 rst_n = 1'b0;
    #1 chk("async rst m", {bus.valid_m, bus.memwrite_m, bus.load_store_m}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(r_ins(7'h00,2,1,0,3), 1'b1);
    tick();
    drive(32'h0, 1'b0);
    chk("post rst e", {bus.valid_e, bus.alucontrol_e, bus.rd_e}, {1'b1, 5'd1, 5'd3});
    chk("post rst m", {bus.valid_m, bus.memwrite_m}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
